tmds_pll_sequencer: RTL

TMDS_PLL_SEQUENCER -- requirements
Module: tmds_pll_sequencer

---
 rtl/tmds_pll_sequencer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/tmds_pll_sequencer.sv
// -----------------------------------------------------------------------------
// tmds_pll_sequencer
//
// Brings up a Gowin rPLL and the TMDS output path in a safe order:
// pulse the PLL reset, wait for lock, require lock to stay high for a
// while, release the serializer, then release the pixel domain a few
// cycles later. Lock loss after release restarts the whole sequence.
// Repeated lock timeouts end in a latched FAULT state.
//
// Optional feature macro: TMDS_SEQ_RETRY_EN
//   defined   : a lock timeout retries the PLL reset up to MAX_RETRIES times
//               before giving up in FAULT.
//   undefined : the first lock timeout goes straight to FAULT and
//               retry_count is always 0.
//
// Ports
//   clkin       in   free-running reference clock (only clock)
//   reset       in   asynchronous active-high reset
//   pll_lock    in   rPLL LOCK, asynchronous to clkin
//   restart     in   synchronous request to re-run the sequence
//   pll_reset   out  rPLL RESET, active-high
//   serdes_rst  out  TMDS serializer reset, active-high
//   pix_rst     out  pixel-domain reset, active-high
//   ready       out  high only while running
//   fault       out  high only in the fault state
//   lock_lost   out  one-cycle pulse when lock drops after release
//   retry_count out  lock timeouts since last run entry / restart / reset
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tmds_pll_sequencer #(
  parameter int PLL_RST_CYCLES   = 16,
  parameter int LOCK_WAIT_CYCLES = 27000,
  parameter int STABLE_CYCLES    = 2700,
  parameter int RELEASE_GAP      = 8,
  parameter int MAX_RETRIES      = 7
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       serdes_rst,
  output logic       pix_rst,
  output logic       ready,
  output logic       fault,
  output logic       lock_lost,
  output logic [3:0] retry_count
);

  typedef enum logic [2:0] {
    PLL_RST    = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    REL_SERDES = 3'd3,
    RUN        = 3'd4,
    FAULT      = 3'd5
  } state_t;

  // Terminal values of the shared counter for each timed state.
  localparam logic [23:0] PLL_RST_LAST = 24'(PLL_RST_CYCLES - 1);
  localparam logic [23:0] LOCK_WAIT_LAST = 24'(LOCK_WAIT_CYCLES - 1);
  localparam logic [23:0] STABLE_LAST = 24'(STABLE_CYCLES - 1);
  localparam logic [23:0] RELEASE_LAST = 24'(RELEASE_GAP - 1);
  localparam logic [23:0] CNT_MAX = 24'hFF_FFFF;

`ifdef TMDS_SEQ_RETRY_EN
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);
`endif

  // retry_count is 4 bits wide, so a larger limit could never be honoured.
  if (MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_bad_max_retries
    $error("tmds_pll_sequencer: MAX_RETRIES must be in 1..15");
  end

  logic        sync_meta;
  logic        sync_lock;
  state_t      state_q;
  state_t      state_next;
  logic [23:0] cnt_q;
  logic        cnt_clear;
  logic [3:0]  retry_q;
  logic [3:0]  retry_next;
  logic        loss_event;

  logic        pll_reset_d;
  logic        serdes_rst_d;
  logic        pix_rst_d;
  logic        ready_d;
  logic        fault_d;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_lock <= 1'b0;
    end else begin
      sync_meta <= pll_lock;
      sync_lock <= sync_meta;
    end
  end

  // State register plus the shared cycle counter and retry counter.
  // The counter restarts on every state change and on restart (which may
  // re-enter PLL_RST from PLL_RST); otherwise it saturates.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q <= PLL_RST;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_next;
      retry_q <= retry_next;
      if (cnt_clear || (state_next != state_q)) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 24'd1;
      end
    end
  end

  // Next-state logic. restart overrides every other condition, including
  // a lock loss or timeout on the same cycle.
  always_comb begin
    state_next = state_q;
    cnt_clear  = 1'b0;
    loss_event = 1'b0;
    retry_next = retry_q;
    if (restart) begin
      state_next = PLL_RST;
      cnt_clear  = 1'b1;
      retry_next = '0;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (cnt_q == PLL_RST_LAST) begin
            state_next = WAIT_LOCK;
          end
        end
        WAIT_LOCK: begin
          if (sync_lock) begin
            state_next = STABLE;
          end else if (cnt_q == LOCK_WAIT_LAST) begin
`ifdef TMDS_SEQ_RETRY_EN
            if (retry_q >= RETRY_LIMIT) begin
              state_next = FAULT;
            end else begin
              state_next = PLL_RST;
              retry_next = retry_q + 4'd1;
            end
`else
            state_next = FAULT;
`endif
          end
        end
        STABLE: begin
          if (!sync_lock) begin
            state_next = WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_next = REL_SERDES;
          end
        end
        REL_SERDES: begin
          if (!sync_lock) begin
            state_next = PLL_RST;
            loss_event = 1'b1;
          end else if (cnt_q == RELEASE_LAST) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (!sync_lock) begin
            state_next = PLL_RST;
            loss_event = 1'b1;
          end
        end
        FAULT: begin
          state_next = FAULT;
        end
        default: begin
          state_next = PLL_RST;
          cnt_clear  = 1'b1;
        end
      endcase
    end
    if ((state_next == RUN) && (state_q != RUN)) begin
      retry_next = '0;
    end
`ifndef TMDS_SEQ_RETRY_EN
    retry_next = '0;
`endif
  end

  // Output decode from the state about to be entered, so the registered
  // outputs line up with the state held after each edge.
  always_comb begin
    pll_reset_d  = (state_next == PLL_RST) || (state_next == FAULT);
    serdes_rst_d = !((state_next == REL_SERDES) || (state_next == RUN));
    pix_rst_d    = (state_next != RUN);
    ready_d      = (state_next == RUN);
    fault_d      = (state_next == FAULT);
  end

  // Output registers.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      pll_reset   <= 1'b1;
      serdes_rst  <= 1'b1;
      pix_rst     <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= '0;
    end else begin
      pll_reset   <= pll_reset_d;
      serdes_rst  <= serdes_rst_d;
      pix_rst     <= pix_rst_d;
      ready       <= ready_d;
      fault       <= fault_d;
      lock_lost   <= loss_event;
      retry_count <= retry_next;
    end
  end

endmodule
